// File: rtl/qp_lut_cam.sv
// IPv4 -> QP number lookup table, scanned one entry per clock after a lookup is accepted.
// Results are held behind a valid/ready handshake; hit/miss totals saturate.
module qp_lut_cam #(
    parameter int unsigned NUM_ENTRY  = 8,
    parameter int unsigned QPN_W      = 4,
    parameter int unsigned MATCH_MODE = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_wr_en,
    input  logic [$clog2(NUM_ENTRY)-1:0] cfg_addr,
    input  logic [31:0]                  cfg_ip,
    input  logic [QPN_W-1:0]             cfg_qpn,
    input  logic                         cfg_vld,
    input  logic                         cfg_clr_all,
    input  logic                         lkp_valid,
    output logic                         lkp_ready,
    input  logic [31:0]                  lkp_ip,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_hit,
    output logic [QPN_W-1:0]             rsp_qpn,
    output logic [$clog2(NUM_ENTRY)-1:0] rsp_idx,
    output logic [CNT_W-1:0]             hit_cnt,
    output logic [CNT_W-1:0]             miss_cnt
);
    localparam int unsigned AW = $clog2(NUM_ENTRY);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ENTRY - 1);
    localparam logic [AW:0] ENTRY_LIM = (AW + 1)'(NUM_ENTRY);
    localparam logic [31:0] KEY_MASK = (MATCH_MODE == 0) ? 32'h0000_00ff : 32'hffff_ffff;

    typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]          tbl_key [NUM_ENTRY];
    logic [QPN_W-1:0]     tbl_qpn [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] tbl_vld;
    logic [31:0]          key;
    logic [AW-1:0]        idx;
    logic                 match;
    logic                 wr_ok;

    assign wr_ok = cfg_wr_en && ({1'b0, cfg_addr} < ENTRY_LIM);

    // Compare reads the table before this edge's write, so same-cycle writes are not seen.
    always_comb begin
        state_nxt = state;
        match     = tbl_vld[idx] && (((tbl_key[idx] ^ key) & KEY_MASK) == 32'h0);
        case (state)
            IDLE:    if (lkp_valid) state_nxt = SEARCH;
            SEARCH:  if (match || (idx == LAST_IDX)) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Table storage; clear-all wins over a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_vld <= '0;
            for (int i = 0; i < int'(NUM_ENTRY); i++) begin
                tbl_key[i] <= '0;
                tbl_qpn[i] <= '0;
            end
        end else if (cfg_clr_all) begin
            tbl_vld <= '0;
        end else if (wr_ok) begin
            tbl_key[cfg_addr] <= cfg_ip;
            tbl_qpn[cfg_addr] <= cfg_qpn;
            tbl_vld[cfg_addr] <= cfg_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lkp_ready <= 1'b1;
            rsp_valid <= 1'b0;
            key       <= '0;
            idx       <= '0;
            rsp_hit   <= 1'b0;
            rsp_qpn   <= '0;
            rsp_idx   <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            lkp_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            if (state == IDLE && lkp_valid) begin
                key <= lkp_ip;
                idx <= '0;
            end
            // Result registers load only on the SEARCH->RESP edge, then stay frozen.
            if (state == SEARCH) begin
                if (match) begin
                    rsp_hit <= 1'b1;
                    rsp_qpn <= tbl_qpn[idx];
                    rsp_idx <= idx;
                    if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + CNT_W'(1);
                end else if (idx == LAST_IDX) begin
                    rsp_hit <= 1'b0;
                    rsp_qpn <= '0;
                    rsp_idx <= '0;
                    if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + CNT_W'(1);
                end else begin
                    idx <= idx + AW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_qp_lut_cam.sv
// Scoreboard bench for qp_lut_cam: two instances (last-octet / full-key match, wide / 2-bit counters)
// share stimulus; expected responses come from a table-scan reference model.
module tb_qp_lut_cam;
    localparam int NE = 8;

    typedef struct {
        logic       hit;
        logic [3:0] qpn;
        logic [2:0] idx;
        int         lat;
        int         acc;
        int         hc;
        int         mc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_ip = '0;
    logic [3:0]  cfg_qpn = '0;
    logic        cfg_vld = 1'b0;
    logic        cfg_clr_all = 1'b0;
    logic        lkp_valid = 1'b0;
    logic [31:0] lkp_ip = '0;
    logic        rsp_ready = 1'b0;

    logic        lr0, rv0, rh0, lr1, rv1, rh1;
    logic [3:0]  rq0, rq1;
    logic [2:0]  ri0, ri1;
    logic [15:0] hc0, mc0;
    logic [1:0]  hc1, mc1;

    int    cyc = 0;
    int    total = 0;
    int    passed = 0;
    int    bp_mode = 0;
    item_t sbq0[$];
    item_t sbq1[$];
    item_t cur[2];
    bit    act[2];
    bit    chk_idle[2];

    logic [31:0] m_key[NE];
    logic [3:0]  m_qpn[NE];
    bit          m_vld[NE];
    int          nh[2];
    int          nm[2];

    qp_lut_cam #(.NUM_ENTRY(8), .QPN_W(4), .MATCH_MODE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_ip(cfg_ip),
        .cfg_qpn(cfg_qpn), .cfg_vld(cfg_vld), .cfg_clr_all(cfg_clr_all), .lkp_valid(lkp_valid),
        .lkp_ready(lr0), .lkp_ip(lkp_ip), .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_hit(rh0),
        .rsp_qpn(rq0), .rsp_idx(ri0), .hit_cnt(hc0), .miss_cnt(mc0)
    );

    qp_lut_cam #(.NUM_ENTRY(8), .QPN_W(4), .MATCH_MODE(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_ip(cfg_ip),
        .cfg_qpn(cfg_qpn), .cfg_vld(cfg_vld), .cfg_clr_all(cfg_clr_all), .lkp_valid(lkp_valid),
        .lkp_ready(lr1), .lkp_ip(lkp_ip), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_hit(rh1),
        .rsp_qpn(rq1), .rsp_idx(ri1), .hit_cnt(hc1), .miss_cnt(mc1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: random backpressure unless a test pins rsp_ready.
    always @(posedge clk) begin
        #2;
        if (bp_mode == 0) rsp_ready = ($urandom_range(0, 3) != 0);
        else rsp_ready = (bp_mode == 2);
    end

    function automatic void chk(input string name, input int d, input int got, input int exp_v);
        total++;
        if (got == exp_v) passed++;
        else $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, d, got, exp_v, cyc);
    endfunction

    function automatic int sat(input int n, input int d);
        int mx;
        mx = (d == 0) ? 65535 : 3;
        return (n > mx) ? mx : n;
    endfunction

    // Reference: lowest valid entry whose key matches under the instance's compare rule.
    function automatic item_t model_rsp(input int d, input logic [31:0] ip);
        item_t e;
        e.hit = 1'b0; e.qpn = '0; e.idx = '0; e.lat = NE; e.acc = 0; e.hc = 0; e.mc = 0;
        for (int i = NE - 1; i >= 0; i--) begin
            if (m_vld[i] && ((d == 1) ? (m_key[i] == ip) : (m_key[i][7:0] == ip[7:0]))) begin
                e.hit = 1'b1; e.qpn = m_qpn[i]; e.idx = 3'(i); e.lat = i + 1;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_ip();
        return {8'd192, 8'd168, 8'($urandom_range(1, 2)), 8'($urandom_range(10, 15))};
    endfunction

    task automatic push_exp(input int d, input item_t e_in);
        item_t e;
        e = e_in;
        e.acc = cyc;
        if (e.hit) nh[d]++;
        else nm[d]++;
        e.hc = sat(nh[d], d);
        e.mc = sat(nm[d], d);
        if (d == 0) sbq0.push_back(e);
        else sbq1.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq0.size() != 0 || sbq1.size() != 0 || act[0] || act[1]) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            total++;
            $display("FAIL idle_timeout: %0d/%0d responses still pending after %0d cycles",
                     sbq0.size(), sbq1.size(), n);
            sbq0.delete(); sbq1.delete();
            act[0] = 0; act[1] = 0;
        end
    endtask

    task automatic cfg_write(input int a, input logic [31:0] ip, input logic [3:0] qp,
                             input logic v, input logic clr, input logic wr);
        cfg_wr_en = wr; cfg_addr = 3'(a); cfg_ip = ip; cfg_qpn = qp; cfg_vld = v; cfg_clr_all = clr;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0; cfg_clr_all = 1'b0;
        if (clr) begin
            for (int i = 0; i < NE; i++) m_vld[i] = 1'b0;
        end else if (wr) begin
            m_key[a] = ip; m_qpn[a] = qp; m_vld[a] = v;
        end
    endtask

    task automatic do_lookup(input logic [31:0] ip);
        item_t e0, e1;
        wait_idle();
        e0 = model_rsp(0, ip);
        e1 = model_rsp(1, ip);
        lkp_ip = ip; lkp_valid = 1'b1;
        @(posedge clk); #1;
        lkp_valid = 1'b0;
        push_exp(0, e0);
        push_exp(1, e1);
    endtask

    // Monitor: pop on the first cycle of each response, then require it to hold until taken.
    always @(negedge clk) begin : mon
        logic       v, lr, h;
        logic [3:0] q;
        logic [2:0] ix;
        int         hcv, mcv;
        item_t      e;
        bit         found;
        for (int d = 0; d < 2; d++) begin
            v   = (d == 0) ? rv0 : rv1;
            lr  = (d == 0) ? lr0 : lr1;
            h   = (d == 0) ? rh0 : rh1;
            q   = (d == 0) ? rq0 : rq1;
            ix  = (d == 0) ? ri0 : ri1;
            hcv = (d == 0) ? int'(hc0) : int'(hc1);
            mcv = (d == 0) ? int'(mc0) : int'(mc1);
            if (rst) begin
                act[d] = 0; chk_idle[d] = 0;
            end else if (v) begin
                if (!act[d]) begin
                    found = 0;
                    if (d == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); found = 1; end
                    if (d == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); found = 1; end
                    if (!found) begin
                        chk("unexpected_rsp_valid", d, int'(v), 0);
                    end else begin
                        cur[d] = e; act[d] = 1;
                        chk("rsp_hit", d, int'(h), int'(e.hit));
                        chk("rsp_qpn", d, int'(q), int'(e.qpn));
                        chk("rsp_idx", d, int'(ix), int'(e.idx));
                        chk("rsp_latency", d, cyc - e.acc, e.lat);
                        chk("hit_cnt", d, hcv, e.hc);
                        chk("miss_cnt", d, mcv, e.mc);
                    end
                end else begin
                    chk("hold_rsp_hit", d, int'(h), int'(cur[d].hit));
                    chk("hold_rsp_qpn", d, int'(q), int'(cur[d].qpn));
                    chk("hold_rsp_idx", d, int'(ix), int'(cur[d].idx));
                end
                chk("lkp_ready_in_resp", d, int'(lr), 0);
                if (rsp_ready) begin act[d] = 0; chk_idle[d] = 1; end
            end else begin
                if (act[d]) begin
                    chk("rsp_valid_dropped", d, int'(v), 1);
                    act[d] = 0;
                end
                if (chk_idle[d]) begin
                    chk("idle_after_handshake", d, int'(lr), 1);
                    chk_idle[d] = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        item_t       e;
        logic [31:0] k;
        int          n;
        for (int i = 0; i < NE; i++) begin m_key[i] = '0; m_qpn[i] = '0; m_vld[i] = 1'b0; end
        nh[0] = 0; nh[1] = 0; nm[0] = 0; nm[1] = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        chk("reset_lkp_ready", 0, int'(lr0), 1);
        chk("reset_lkp_ready", 1, int'(lr1), 1);
        chk("reset_rsp_valid", 0, int'(rv0), 0);
        chk("reset_rsp_hit", 0, int'(rh0), 0);
        chk("reset_rsp_qpn", 0, int'(rq0), 0);
        chk("reset_hit_cnt", 0, int'(hc0), 0);
        chk("reset_miss_cnt", 1, int'(mc1), 0);

        // Empty table: full-length miss.
        do_lookup(32'h0A00_0005);

        // Last-octet match hits entry 2; full-key instance misses.
        cfg_write(2, 32'hC0A8_010C, 4'd3, 1'b1, 1'b0, 1'b1);
        do_lookup(32'h0A00_000C);

        // Duplicate keys: lowest index wins; third octet differs only for full-key mode.
        cfg_write(1, 32'hC0A8_0114, 4'd4, 1'b1, 1'b0, 1'b1);
        cfg_write(5, 32'hC0A8_0114, 4'd8, 1'b1, 1'b0, 1'b1);
        do_lookup(32'hC0A8_0114);
        do_lookup(32'hC0A8_0214);

        // Backpressure: held response survives a clear-all and a competing lookup request.
        wait_idle();
        bp_mode = 1;
        cfg_write(3, 32'hC0A8_0105, 4'd11, 1'b1, 1'b0, 1'b1);
        do_lookup(32'hC0A8_0105);
        n = 0;
        while (!(rv0 && rv1) && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            total++;
            $display("FAIL bp_rsp_timeout: rsp_valid %0b/%0b after %0d cycles", rv0, rv1, n);
        end
        lkp_ip = 32'h0A0A_0A0A; lkp_valid = 1'b1;
        for (int k2 = 0; k2 < 10; k2++) begin
            if (k2 == 5) cfg_write(0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0);
            else begin @(posedge clk); #1; end
        end
        lkp_valid = 1'b0;
        bp_mode = 2;
        wait_idle();
        bp_mode = 0;

        // Clear-all beats a same-edge write.
        cfg_write(0, 32'hC0A8_0163, 4'd5, 1'b1, 1'b0, 1'b1);
        cfg_write(2, 32'hC0A8_0199, 4'd6, 1'b1, 1'b1, 1'b1);
        do_lookup(32'hC0A8_0199);
        do_lookup(32'hC0A8_0163);

        // Writes during a scan: entry 0 is written after it was compared, entry 5 before.
        wait_idle();
        k = 32'hC0A8_0321;
        lkp_ip = k; lkp_valid = 1'b1;
        @(posedge clk); #1;
        lkp_valid = 1'b0;
        e.hit = 1'b1; e.qpn = 4'd9; e.idx = 3'd5; e.lat = 6; e.acc = 0; e.hc = 0; e.mc = 0;
        push_exp(0, e);
        push_exp(1, e);
        cfg_write(0, k, 4'd7, 1'b1, 1'b0, 1'b1);
        cfg_write(5, k, 4'd9, 1'b1, 1'b0, 1'b1);
        do_lookup(k);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 250; it++) begin
            wait_idle();
            n = $urandom_range(0, 3);
            for (int w = 0; w < n; w++)
                cfg_write($urandom_range(0, 7), rnd_ip(), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), 1'b1);
            do_lookup(rnd_ip());
        end
        wait_idle();
        chk("hit_cnt_saturated", 1, int'(hc1), sat(nh[1], 1));
        chk("miss_cnt_final", 0, int'(mc0), sat(nm[0], 0));

        // Reset in the middle of a long scan: no response afterwards, everything cleared.
        cfg_write(7, 32'hC0A8_0177, 4'd1, 1'b1, 1'b0, 1'b1);
        lkp_ip = 32'hC0A8_0177; lkp_valid = 1'b1;
        @(posedge clk); #1;
        lkp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NE; i++) begin m_key[i] = '0; m_qpn[i] = '0; m_vld[i] = 1'b0; end
        nh[0] = 0; nh[1] = 0; nm[0] = 0; nm[1] = 0;
        @(posedge clk); #1;
        chk("inreset_rsp_valid", 0, int'(rv0), 0);
        chk("inreset_lkp_ready", 1, int'(lr1), 1);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("post_reset_hit_cnt", 0, int'(hc0), 0);
        chk("post_reset_miss_cnt", 0, int'(mc0), 0);
        chk("post_reset_hit_cnt", 1, int'(hc1), 0);
        chk("post_reset_lkp_ready", 0, int'(lr0), 1);
        do_lookup(32'hC0A8_0177);
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/qp_lut_cam.md
QP_LUT_CAM -- requirements
Module: qp_lut_cam

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 8, number of table entries (2..64).
REQ-002 SHALL have parameter QPN_W, default 4, width of returned QP number.
REQ-003 SHALL have parameter MATCH_MODE, default 0, 0 = compare IPv4 last octet only, 1 = compare full 32-bit IPv4.
REQ-004 SHALL have parameter CNT_W, default 16, width of hit/miss counters.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cfg_wr_en  input  1  write one table entry this cycle.
REQ-008 SHALL have port cfg_addr  input  $clog2(NUM_ENTRY)  entry index to write.
REQ-009 SHALL have port cfg_ip  input  32  host IPv4 key for entry.
REQ-010 SHALL have port cfg_qpn  input  QPN_W  QP number for entry.
REQ-011 SHALL have port cfg_vld  input  1  entry valid bit written with entry.
REQ-012 SHALL have port cfg_clr_all  input  1  invalidate all entries.
REQ-013 SHALL have port lkp_valid  input  1  lookup request valid.
REQ-014 SHALL have port lkp_ready  output  1  block can accept a lookup.
REQ-015 SHALL have port lkp_ip  input  32  IPv4 to look up.
REQ-016 SHALL have port rsp_valid  output  1  lookup result valid.
REQ-017 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-018 SHALL have ports rsp_hit (output 1), rsp_qpn (output QPN_W), rsp_idx (output $clog2(NUM_ENTRY)): hit flag, QP number, matching index.
REQ-019 SHALL have ports hit_cnt, miss_cnt  output  CNT_W  saturating lookup statistics.

Function
REQ-020 SHALL implement FSM states IDLE, SEARCH, RESP; lkp_ready = 1 only in IDLE.
REQ-021 SHALL, on lkp_valid & lkp_ready at an edge, latch lkp_ip, set search index to 0, enter SEARCH.
REQ-022 SHALL in SEARCH compare one entry per cycle (index i): match = valid[i] & key equality per MATCH_MODE.
REQ-023 SHALL on match enter RESP with rsp_hit=1, rsp_qpn=qpn[i], rsp_idx=i; lowest matching index wins.
REQ-024 SHALL on no match at i = NUM_ENTRY-1 enter RESP with rsp_hit=0, rsp_qpn=0, rsp_idx=0; else increment index.
REQ-025 SHALL assert rsp_valid i+1 clocks after acceptance edge for hit at entry i, NUM_ENTRY clocks for miss.
REQ-026 SHALL in RESP hold rsp_valid and all rsp_* stable until rsp_valid & rsp_ready at an edge, then enter IDLE; rsp_valid low outside RESP.
REQ-027 SHALL update table entry cfg_addr (key, qpn, valid) at the edge where cfg_wr_en = 1; writes accepted in every state.
REQ-028 SHALL ignore cfg_wr_en when cfg_addr >= NUM_ENTRY.
REQ-029 SHALL compare against pre-write contents when a write targets the entry being compared in the same cycle; entries already passed are not revisited.
REQ-030 SHALL on cfg_clr_all clear every valid bit at that edge; cfg_clr_all has priority over a same-cycle cfg_wr_en.
REQ-031 SHALL increment hit_cnt or miss_cnt by 1 on the edge entering RESP; each saturates at all-ones.
REQ-032 SHALL keep responses unaffected by table writes once in RESP.

Reset
REQ-033 SHALL on rst asynchronously force IDLE, all valid bits, keys, qpn values, rsp_* , hit_cnt, miss_cnt to 0; lkp_ready = 1 after release.
REQ-034 SHALL discard an in-flight lookup when rst asserts mid-SEARCH or mid-RESP; no response issued afterwards.

Verification
REQ-035 SHALL verify hit: MATCH_MODE=0, entry2 = {ip 192.168.1.12, qpn 3, vld 1}, lookup 10.0.0.12 -> rsp_hit=1, rsp_qpn=3, rsp_idx=2, rsp_valid 3 clocks after acceptance, hit_cnt=1.
REQ-036 SHALL verify miss: empty table, lookup any IP -> rsp_hit=0, rsp_qpn=0, rsp_valid after 8 clocks, miss_cnt=1.
REQ-037 SHALL verify duplicate/mode: entries 1 and 5 both key 192.168.1.20, MATCH_MODE=1 -> rsp_idx=1; lookup 192.168.2.20 -> miss.
REQ-038 SHALL verify backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, lkp_ready=0, no new acceptance; rsp_ready=1 -> IDLE next edge.
REQ-039 SHALL verify clear/write priority: cfg_clr_all and cfg_wr_en same edge -> all entries invalid; subsequent lookup of written key misses.
REQ-040 SHALL verify reset mid-SEARCH and counter saturation (CNT_W=2, 5 hits -> hit_cnt=3).
